// File: rtl/sdp_mrdma_pkg.sv
// Shared definitions for the SDP memory-RDMA read-response generator.
// Holds pd field offsets, mask encodings and the FSM state type.
package sdp_mrdma_pkg;

    localparam int REQ_ADDR_LSB = 0;
    localparam int REQ_ADDR_MSB = 63;
    localparam int REQ_SIZE_LSB = 64;
    localparam int REQ_SIZE_MSB = 78;
    localparam int REQ_PD_W     = 79;

    localparam int RSP_LO_LSB   = 0;
    localparam int RSP_LO_MSB   = 255;
    localparam int RSP_HI_LSB   = 256;
    localparam int RSP_HI_MSB   = 511;
    localparam int RSP_MASK_LSB = 512;
    localparam int RSP_MASK_MSB = 513;
    localparam int RSP_PD_W     = 514;

    localparam logic [1:0] MASK_LO   = 2'b01;
    localparam logic [1:0] MASK_HI   = 2'b10;
    localparam logic [1:0] MASK_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD0  = 2'd1,
        ST_RD1  = 2'd2,
        ST_SEND = 2'd3
    } state_t;

endpackage

// File: rtl/sdp_mrdma_cdt_cnt.sv
// Response-credit counter for the read-response generator.
// Saturates at DEPTH and flags a sticky overflow on an extra return.
module sdp_mrdma_cdt_cnt #(
    parameter int DEPTH = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_overflow
);

    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          w_full;

    assign w_full     = (r_count == CW'(DEPTH));
    assign o_count    = r_count;
    assign o_overflow = r_ovf;

    // Track outstanding credits; simultaneous inc/dec cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= CW'(DEPTH);
            r_ovf   <= 1'b0;
        end else begin
            case ({i_inc, i_dec})
                2'b10: begin
                    if (w_full) r_ovf <= 1'b1;
                    else        r_count <= r_count + CW'(1);
                end
                2'b01: begin
                    if (r_count != '0) r_count <= r_count - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sdp_mrdma_rd_rsp_gen.sv
// Read-response generator: turns one read request into 32B/64B beats
// fetched from a 1-cycle-latency memory, throttled by response credits.
module sdp_mrdma_rd_rsp_gen
    import sdp_mrdma_pkg::*;
#(
    parameter int LAT_FIFO_DEPTH = 64,
    parameter int MEM_AW         = 20
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rst,
    input  logic                sdp2mcif_rd_req_valid,
    output logic                sdp2mcif_rd_req_ready,
    input  logic [REQ_PD_W-1:0] sdp2mcif_rd_req_pd,
    output logic                mem_rd_en,
    output logic [MEM_AW-1:0]   mem_rd_addr,
    input  logic [255:0]        mem_rd_data,
    output logic                mcif2sdp_rd_rsp_valid,
    input  logic                mcif2sdp_rd_rsp_ready,
    output logic [RSP_PD_W-1:0] mcif2sdp_rd_rsp_pd,
    input  logic                sdp2mcif_rd_cdt_lat_fifo_pop,
    output logic                cdt_overflow
);

    localparam int CW = $clog2(LAT_FIFO_DEPTH + 1);

    state_t              r_state;
    logic [63:0]         r_addr;
    logic [15:0]         r_rem;
    logic                r_pair;
    logic                r_cap;
    logic                r_valid;
    logic [RSP_PD_W-1:0] r_pd;

    logic                w_req_hs;
    logic                w_rsp_hs;
    logic [CW-1:0]       w_credit;
    logic                w_cdt_ok;
    logic [15:0]         w_size_p1;
    logic [15:0]         w_step;
    logic [63:0]         w_adv;
    logic [MEM_AW-1:0]   w_atom;

    assign sdp2mcif_rd_req_ready = (r_state == ST_IDLE) & ~nvdla_core_rst;
    assign w_req_hs  = sdp2mcif_rd_req_valid & sdp2mcif_rd_req_ready;
    assign w_rsp_hs  = r_valid & mcif2sdp_rd_rsp_ready;
    assign w_cdt_ok  = (w_credit != '0);
    assign w_size_p1 = 16'({1'b0,
        sdp2mcif_rd_req_pd[REQ_SIZE_MSB:REQ_SIZE_LSB]}) + 16'd1;
    assign w_step    = r_pair ? 16'd2 : 16'd1;
    assign w_adv     = r_pair ? 64'd64 : 64'd32;
    assign w_atom    = r_addr[MEM_AW+4:5];

    assign mem_rd_en   = ((r_state == ST_RD0) | (r_state == ST_RD1))
                       & ~nvdla_core_rst;
    assign mem_rd_addr = (r_state == ST_RD1) ? w_atom + MEM_AW'(1)
                                             : w_atom;

    assign mcif2sdp_rd_rsp_valid = r_valid;
    assign mcif2sdp_rd_rsp_pd    = r_pd;

    sdp_mrdma_cdt_cnt #(
        .DEPTH (LAT_FIFO_DEPTH),
        .CW    (CW)
    ) u_cdt (
        .clk        (nvdla_core_clk),
        .rst        (nvdla_core_rst),
        .i_inc      (sdp2mcif_rd_cdt_lat_fifo_pop),
        .i_dec      (w_rsp_hs),
        .o_count    (w_credit),
        .o_overflow (cdt_overflow)
    );

    // Request walker: fetch one or two atoms, build the beat, hand it off.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_pair  <= 1'b0;
            r_cap   <= 1'b0;
            r_valid <= 1'b0;
            r_pd    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_hs) begin
                        r_addr  <= sdp2mcif_rd_req_pd[REQ_ADDR_MSB:REQ_ADDR_LSB];
                        r_rem   <= w_size_p1;
                        r_state <= ST_RD0;
                    end
                end
                ST_RD0: begin
                    if (!r_addr[5] && (r_rem >= 16'd2)) begin
                        r_pair  <= 1'b1;
                        r_state <= ST_RD1;
                    end else begin
                        r_pair  <= 1'b0;
                        r_cap   <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_RD1: begin
                    r_pd[RSP_LO_MSB:RSP_LO_LSB] <= mem_rd_data;
                    r_cap   <= 1'b1;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (r_cap) begin
                        r_cap   <= 1'b0;
                        r_valid <= w_cdt_ok;
                        if (r_pair) begin
                            r_pd[RSP_HI_MSB:RSP_HI_LSB]     <= mem_rd_data;
                            r_pd[RSP_MASK_MSB:RSP_MASK_LSB] <= MASK_BOTH;
                        end else if (r_addr[5]) begin
                            r_pd[RSP_HI_MSB:RSP_HI_LSB]     <= mem_rd_data;
                            r_pd[RSP_LO_MSB:RSP_LO_LSB]     <= '0;
                            r_pd[RSP_MASK_MSB:RSP_MASK_LSB] <= MASK_HI;
                        end else begin
                            r_pd[RSP_HI_MSB:RSP_HI_LSB]     <= '0;
                            r_pd[RSP_LO_MSB:RSP_LO_LSB]     <= mem_rd_data;
                            r_pd[RSP_MASK_MSB:RSP_MASK_LSB] <= MASK_LO;
                        end
                    end else if (!r_valid) begin
                        r_valid <= w_cdt_ok;
                    end else if (mcif2sdp_rd_rsp_ready) begin
                        r_valid <= 1'b0;
                        r_addr  <= r_addr + w_adv;
                        r_rem   <= r_rem - w_step;
                        r_state <= (r_rem == w_step) ? ST_IDLE : ST_RD0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdp_mrdma_rd_rsp_gen.sv
// Directed self-checking bench for sdp_mrdma_rd_rsp_gen.
// Two instances: default credit depth and a depth-2 credit-stall case.
module tb_sdp_mrdma_rd_rsp_gen;

    logic         clk = 1'b0;
    logic         rst;
    int           n_tests = 0;
    int           n_fail  = 0;

    logic         rqv1, rqr1, rde1, rsv1, rsr1, pop1, ovf1;
    logic [78:0]  rqpd1;
    logic [19:0]  rda1;
    logic [255:0] rdd1;
    logic [513:0] rspd1;

    logic         rqv2, rqr2, rde2, rsv2, rsr2, pop2, ovf2;
    logic [78:0]  rqpd2;
    logic [19:0]  rda2;
    logic [255:0] rdd2;
    logic [513:0] rspd2;

    always #5 clk = ~clk;

    sdp_mrdma_rd_rsp_gen u_dut (
        .nvdla_core_clk               (clk),
        .nvdla_core_rst               (rst),
        .sdp2mcif_rd_req_valid        (rqv1),
        .sdp2mcif_rd_req_ready        (rqr1),
        .sdp2mcif_rd_req_pd           (rqpd1),
        .mem_rd_en                    (rde1),
        .mem_rd_addr                  (rda1),
        .mem_rd_data                  (rdd1),
        .mcif2sdp_rd_rsp_valid        (rsv1),
        .mcif2sdp_rd_rsp_ready        (rsr1),
        .mcif2sdp_rd_rsp_pd           (rspd1),
        .sdp2mcif_rd_cdt_lat_fifo_pop (pop1),
        .cdt_overflow                 (ovf1)
    );

    sdp_mrdma_rd_rsp_gen #(.LAT_FIFO_DEPTH(2)) u_d2 (
        .nvdla_core_clk               (clk),
        .nvdla_core_rst               (rst),
        .sdp2mcif_rd_req_valid        (rqv2),
        .sdp2mcif_rd_req_ready        (rqr2),
        .sdp2mcif_rd_req_pd           (rqpd2),
        .mem_rd_en                    (rde2),
        .mem_rd_addr                  (rda2),
        .mem_rd_data                  (rdd2),
        .mcif2sdp_rd_rsp_valid        (rsv2),
        .mcif2sdp_rd_rsp_ready        (rsr2),
        .mcif2sdp_rd_rsp_pd           (rspd2),
        .sdp2mcif_rd_cdt_lat_fifo_pop (pop2),
        .cdt_overflow                 (ovf2)
    );

    function automatic logic [255:0] atom(input logic [19:0] a);
        return {8{12'hD00, a}};
    endfunction

    function automatic logic [513:0] bpair(input logic [19:0] a);
        return {2'b11, atom(a + 20'd1), atom(a)};
    endfunction

    function automatic logic [513:0] blo(input logic [19:0] a);
        return {2'b01, 256'b0, atom(a)};
    endfunction

    function automatic logic [513:0] bhi(input logic [19:0] a);
        return {2'b10, atom(a), 256'b0};
    endfunction

    // Backing memories with one cycle of read latency.
    always @(posedge clk) begin
        if (rde1) rdd1 <= atom(rda1);
        if (rde2) rdd2 <= atom(rda2);
    end

    task automatic chk(input string tag, input logic [513:0] obs,
                       input logic [513:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input bit d2, output int c);
        c = 0;
        while (!(d2 ? rsv2 : rsv1) && c < 20) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic req(input bit d2, input logic [63:0] a,
                       input logic [14:0] s);
        if (d2) begin rqv2 = 1'b1; rqpd2 = {s, a}; end
        else    begin rqv1 = 1'b1; rqpd1 = {s, a}; end
        @(negedge clk);
        rqv1 = 1'b0;
        rqv2 = 1'b0;
    endtask

    task automatic get_beat(input bit d2, input string tag,
                            input logic [513:0] exp, input int lat);
        int c;
        wait_valid(d2, c);
        chk({tag, "_lat"}, c, lat);
        chk({tag, "_pd"}, d2 ? rspd2 : rspd1, exp);
        @(negedge clk);
    endtask

    initial begin
        int c;
        rst = 1'b1;
        rqv1 = 1'b0; rqpd1 = '0; rsr1 = 1'b1; pop1 = 1'b0;
        rqv2 = 1'b0; rqpd2 = '0; rsr2 = 1'b1; pop2 = 1'b0;

        @(negedge clk);
        chk("rst_ready", rqr1, 1'b0);
        chk("rst_rden", rde1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", rqr1, 1'b1);
        chk("idle_valid", rsv1, 1'b0);
        chk("idle_pd", rspd1, '0);
        chk("idle_credit", u_dut.u_cdt.o_count, 64);
        chk("idle_ovf", ovf1, 1'b0);

        req(0, 64'h1000, 15'd3);
        get_beat(0, "p1", bpair(20'h80), 3);
        get_beat(0, "p2", bpair(20'h82), 3);
        chk("p_idle", rqr1, 1'b1);
        chk("p_credit", u_dut.u_cdt.o_count, 62);

        req(0, 64'h1020, 15'd1);
        get_beat(0, "h1", bhi(20'h81), 2);
        get_beat(0, "h2", blo(20'h82), 2);
        chk("h_credit", u_dut.u_cdt.o_count, 60);

        req(0, 64'hFFFF_FFFF_FFFF_FFE0, 15'd1);
        get_beat(0, "w1", bhi(20'hFFFFF), 2);
        get_beat(0, "w2", blo(20'h00000), 2);
        chk("w_credit", u_dut.u_cdt.o_count, 58);

        req(0, 64'h2000, 15'd107);
        for (int k = 0; k < 53; k++)
            get_beat(0, $sformatf("blk%0d", k),
                     bpair(20'h100 + 20'(2 * k)), 3);
        chk("blk_credit", u_dut.u_cdt.o_count, 5);
        rsr1 = 1'b0;
        wait_valid(0, c);
        chk("stall_lat", c, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("stall_v%0d", i), rsv1, 1'b1);
            chk($sformatf("stall_pd%0d", i), rspd1, bpair(20'h16A));
        end
        rsr1 = 1'b1;
        pop1 = 1'b1;
        @(negedge clk);
        pop1 = 1'b0;
        chk("hs_pop_credit", u_dut.u_cdt.o_count, 5);
        chk("hs_pop_idle", rqr1, 1'b1);

        pop1 = 1'b1;
        repeat (59) @(negedge clk);
        pop1 = 1'b0;
        chk("full_credit", u_dut.u_cdt.o_count, 64);
        chk("full_ovf", ovf1, 1'b0);
        pop1 = 1'b1;
        @(negedge clk);
        pop1 = 1'b0;
        chk("ovf_credit", u_dut.u_cdt.o_count, 64);
        chk("ovf_set", ovf1, 1'b1);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", ovf1, 1'b1);

        pop1 = 1'b1;
        req(0, 64'h4000, 15'h7FFF);
        pop1 = 1'b0;
        chk("big_rem", u_dut.r_rem, 16'h8000);
        chk("rd0_en", rde1, 1'b1);
        chk("rd0_addr", rda1, 20'h200);
        @(negedge clk);
        chk("rd1_addr", rda1, 20'h201);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", rqr1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", rqr1, 1'b1);
        chk("post_rst_valid", rsv1, 1'b0);
        chk("post_rst_credit", u_dut.u_cdt.o_count, 64);
        chk("post_rst_ovf", ovf1, 1'b0);
        repeat (6) @(negedge clk);
        chk("post_rst_quiet", rsv1, 1'b0);

        req(1, 64'h0, 15'd0);
        get_beat(1, "d2a", blo(20'h0), 2);
        req(1, 64'h20, 15'd0);
        get_beat(1, "d2b", bhi(20'h1), 2);
        chk("d2_credit0", u_d2.u_cdt.o_count, 0);
        req(1, 64'h40, 15'd0);
        wait_valid(1, c);
        chk("d2_stall3", c, 20);
        pop2 = 1'b1;
        @(negedge clk);
        pop2 = 1'b0;
        get_beat(1, "d2c", blo(20'h2), 1);
        req(1, 64'h60, 15'd0);
        wait_valid(1, c);
        chk("d2_stall4", c, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
